// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single memory-controller port between the data cache (port 0)
//   and the instruction cache (port 1). One requester owns the port for a whole
//   burst. Ports take turns when both request, and one idle turnaround cycle
//   separates consecutive bursts.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   i_pN_addr                     read burst start address / per-beat write address
//   i_pN_in                       write data
//   i_pN_rdreq, i_pN_wrreq        level requests (wrreq also acts as write-beat valid)
//   o_pN_gnt                      port owns the memory port
//   o_pN_out                      mem_out broadcast
//   o_pN_out_valid                read beat for this port
//   o_pN_done                     pulse on the last beat of this port's burst
//   o_mem_addr, o_mem_in          address / write data to memory
//   o_mem_rdreq                   read-burst start pulse
//   o_mem_wrreq                   write beat
//   i_mem_out, i_mem_out_valid    read data / read beat valid
//   i_mem_burstlen                beats per burst (0 is treated as 1)
// -----------------------------------------------------------------------------

// Per-port response decode: a port sees beats and done only while it owns the port.
module mem_arbiter_port #(
    parameter int DATABITS = 32
) (
    input  logic                i_own,
    input  logic                i_read,
    input  logic                i_last,
    input  logic                i_mem_out_valid,
    input  logic [DATABITS-1:0] i_mem_out,
    output logic                o_gnt,
    output logic                o_out_valid,
    output logic                o_done,
    output logic [DATABITS-1:0] o_out
);
    assign o_gnt       = i_own;
    assign o_out_valid = i_own & i_read & i_mem_out_valid;
    assign o_done      = i_own & i_last;
    assign o_out       = i_mem_out;
endmodule

module mem_arbiter #(
    parameter int DATABITS = 32,
    parameter int ADDRBITS = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] i_p0_addr,
    input  logic [DATABITS-1:0] i_p0_in,
    input  logic                i_p0_rdreq,
    input  logic                i_p0_wrreq,
    output logic                o_p0_gnt,
    output logic [DATABITS-1:0] o_p0_out,
    output logic                o_p0_out_valid,
    output logic                o_p0_done,
    input  logic [ADDRBITS-1:0] i_p1_addr,
    input  logic [DATABITS-1:0] i_p1_in,
    input  logic                i_p1_rdreq,
    input  logic                i_p1_wrreq,
    output logic                o_p1_gnt,
    output logic [DATABITS-1:0] o_p1_out,
    output logic                o_p1_out_valid,
    output logic                o_p1_done,
    output logic [ADDRBITS-1:0] o_mem_addr,
    output logic [DATABITS-1:0] o_mem_in,
    output logic                o_mem_rdreq,
    output logic                o_mem_wrreq,
    input  logic [DATABITS-1:0] i_mem_out,
    input  logic                i_mem_out_valid,
    input  logic [15:0]         i_mem_burstlen
);
    localparam int NPORT = 2;

    typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

    state_t                      r_state;
    logic                        r_port;   // granted port
    logic                        r_last;   // last-granted port (tie breaker)
    logic [NPORT-1:0]            r_gnt;
    logic                        r_first;  // first READ cycle: issue mem_rdreq
    logic [ADDRBITS-1:0]         r_addr;
    logic [15:0]                 r_len;
    logic [15:0]                 r_cnt;

    logic [NPORT-1:0][ADDRBITS-1:0] w_addr;
    logic [NPORT-1:0][DATABITS-1:0] w_in;
    logic [NPORT-1:0]               w_wr;
    logic [NPORT-1:0]               w_req;
    logic                           w_pick;
    logic                           w_beat;
    logic                           w_last;
    logic                           w_read;
    logic                           w_write;
    logic [NPORT-1:0]               w_gnt;
    logic [NPORT-1:0]               w_out_valid;
    logic [NPORT-1:0]               w_done;
    logic [NPORT-1:0][DATABITS-1:0] w_out;

    assign w_addr = {i_p1_addr, i_p0_addr};
    assign w_in   = {i_p1_in, i_p0_in};
    assign w_wr   = {i_p1_wrreq, i_p0_wrreq};
    assign w_req  = {i_p1_rdreq | i_p1_wrreq, i_p0_rdreq | i_p0_wrreq};

    // Tie goes to the port that was not granted last.
    assign w_pick = (w_req[0] & w_req[1]) ? ~r_last : w_req[1];

    assign w_read  = (r_state == READ);
    assign w_write = (r_state == WRITE);

    // A beat is a read-data cycle in READ or a granted write-valid cycle in WRITE.
    assign w_beat = (w_read & i_mem_out_valid) | (w_write & w_wr[r_port]);
    assign w_last = w_beat & ((r_cnt + 16'd1) == r_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_port  <= 1'b0;
            r_last  <= 1'b1;
            r_gnt   <= '0;
            r_first <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_port  <= w_pick;
                        r_last  <= w_pick;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_addr  <= w_addr[w_pick];
                        r_len   <= (i_mem_burstlen == 16'd0) ? 16'd1 : i_mem_burstlen;
                        r_cnt   <= '0;
                        // Write wins when both directions are raised on one port.
                        r_first <= ~w_wr[w_pick];
                        r_state <= w_wr[w_pick] ? WRITE : READ;
                    end
                end
                READ, WRITE: begin
                    r_first <= 1'b0;
                    if (w_last) begin
                        r_gnt   <= '0;
                        r_state <= TURN;
                    end else if (w_beat) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Memory side: reads hold the latched address, writes pass the owner through.
    assign o_mem_rdreq = w_read & r_first;
    assign o_mem_wrreq = w_write & w_wr[r_port];
    assign o_mem_addr  = w_write ? w_addr[r_port] : (w_read ? r_addr : '0);
    assign o_mem_in    = w_write ? w_in[r_port] : '0;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        mem_arbiter_port #(.DATABITS(DATABITS)) u_port (
            .i_own           (r_gnt[p]),
            .i_read          (w_read),
            .i_last          (w_last),
            .i_mem_out_valid (i_mem_out_valid),
            .i_mem_out       (i_mem_out),
            .o_gnt           (w_gnt[p]),
            .o_out_valid     (w_out_valid[p]),
            .o_done          (w_done[p]),
            .o_out           (w_out[p])
        );
    end

    assign o_p0_gnt       = w_gnt[0];
    assign o_p1_gnt       = w_gnt[1];
    assign o_p0_out_valid = w_out_valid[0];
    assign o_p1_out_valid = w_out_valid[1];
    assign o_p0_done      = w_done[0];
    assign o_p1_done      = w_done[1];
    assign o_p0_out       = w_out[0];
    assign o_p1_out       = w_out[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Inputs change 1 time unit after the rising
//   edge; outputs are compared 1 time unit later within the same cycle.
//   Output vector for outs(): {p0_gnt,p1_gnt,p0_ov,p1_ov,p0_done,p1_done,
//   mem_rdreq,mem_wrreq}.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] p0_addr, p0_in, p1_addr, p1_in;
    logic        p0_rdreq, p0_wrreq, p1_rdreq, p1_wrreq;
    logic        p0_gnt, p0_out_valid, p0_done, p1_gnt, p1_out_valid, p1_done;
    logic [31:0] p0_out, p1_out;
    logic [31:0] mem_addr, mem_in, mem_out;
    logic        mem_rdreq, mem_wrreq, mem_out_valid;
    logic [15:0] mem_burstlen;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATABITS(32), .ADDRBITS(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_p0_addr       (p0_addr),
        .i_p0_in         (p0_in),
        .i_p0_rdreq      (p0_rdreq),
        .i_p0_wrreq      (p0_wrreq),
        .o_p0_gnt        (p0_gnt),
        .o_p0_out        (p0_out),
        .o_p0_out_valid  (p0_out_valid),
        .o_p0_done       (p0_done),
        .i_p1_addr       (p1_addr),
        .i_p1_in         (p1_in),
        .i_p1_rdreq      (p1_rdreq),
        .i_p1_wrreq      (p1_wrreq),
        .o_p1_gnt        (p1_gnt),
        .o_p1_out        (p1_out),
        .o_p1_out_valid  (p1_out_valid),
        .o_p1_done       (p1_done),
        .o_mem_addr      (mem_addr),
        .o_mem_in        (mem_in),
        .o_mem_rdreq     (mem_rdreq),
        .o_mem_wrreq     (mem_wrreq),
        .i_mem_out       (mem_out),
        .i_mem_out_valid (mem_out_valid),
        .i_mem_burstlen  (mem_burstlen)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [7:0] e);
        chk(tag, {p0_gnt, p1_gnt, p0_out_valid, p1_out_valid, p0_done, p1_done,
                  mem_rdreq, mem_wrreq}, e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] wpat;
        logic       mv;
        logic [1:0] prev;
        int         n_g;
        logic       gseq [8];
        int         gcyc [8];
        int         ecyc [4];

        reset_n = 1'b0;
        p0_addr = '0; p0_in = '0; p1_addr = '0; p1_in = '0;
        p0_rdreq = 0; p0_wrreq = 0; p1_rdreq = 0; p1_wrreq = 0;
        mem_out = 32'hCAFE0001; mem_out_valid = 0; mem_burstlen = 16'd4;

        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1;
        outs("rst_outs", 8'h00);
        chk("rst_addr", mem_addr, 0);
        chk("rst_in", mem_in, 0);
        chk("rst_p0_out", p0_out, 32'hCAFE0001);
        chk("rst_p1_out", p1_out, 32'hCAFE0001);
        reset_n = 1'b1;
        nxt();

        // ---------------- T1: port 0 read, len 4, beats 3,4,6,7 after rdreq
        mem_burstlen = 16'd4; p0_addr = 32'h1000; p0_rdreq = 1;
        #1 outs("t1_idle", 8'h00);
        nxt();
        p0_rdreq = 0; p0_addr = 32'h2000;   // both ignored: request latched
        #1 outs("t1_rdreq", 8'b1000_0010);
        chk("t1_addr", mem_addr, 32'h1000);
        nxt();
        for (int k = 1; k <= 7; k++) begin
            mv = (k == 3 || k == 4 || k == 6 || k == 7);
            mem_out_valid = mv;
            mem_out = 32'hD000 + k;
            #1 outs($sformatf("t1_k%0d", k), {1'b1, 1'b0, mv, 1'b0, (k == 7), 3'b000});
            if (k == 3) begin
                chk("t1_hold_addr", mem_addr, 32'h1000);
                chk("t1_p0_out", p0_out, 32'hD003);
            end
            nxt();
        end
        mem_out_valid = 0;
        #1 outs("t1_turn", 8'h00);
        chk("t1_turn_addr", mem_addr, 0);
        nxt();

        // ---------------- T2: tie after reset -> port 0 read, then port 1 write x8
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        mem_burstlen = 16'd1; p0_rdreq = 1; p1_wrreq = 1;
        p1_addr = 32'h3000; p1_in = 32'hA000;
        #1 outs("t2_idle", 8'h00);
        nxt();
        p0_rdreq = 0; mem_burstlen = 16'd8; mem_out_valid = 1;
        #1 outs("t2_p0_beat", 8'b1010_1010);
        nxt();
        mem_out_valid = 0;
        #1 outs("t2_turn", 8'h00);
        nxt();
        #1 outs("t2_idle2", 8'h00);
        nxt();
        for (int k = 0; k < 8; k++) begin
            p1_addr = 32'h3000 + k; p1_in = 32'hA000 + k;
            #1 outs($sformatf("t2_w%0d", k), {1'b0, 1'b1, 3'b000, (k == 7), 1'b0, 1'b1});
            chk($sformatf("t2_waddr%0d", k), mem_addr, 32'h3000 + k);
            chk($sformatf("t2_win%0d", k), mem_in, 32'hA000 + k);
            nxt();
        end
        p1_wrreq = 0;
        #1 outs("t2_turn2", 8'h00);
        nxt();

        // ---------------- T3: both requesting, len 2 -> 0,1,0,1 at cycles 1,6,10,15
        mem_burstlen = 16'd2; p0_addr = 32'h4000; p0_rdreq = 1; p1_wrreq = 1;
        n_g = 0; prev = 2'b00;
        ecyc = '{1, 6, 10, 15};
        for (int c = 0; c < 18; c++) begin
            if (c == 17) begin
                p0_rdreq = 0; p1_wrreq = 0;
            end
            #1 mem_out_valid = !mem_rdreq;   // memory answers from the cycle after rdreq
            #1;
            if (!p0_gnt && !p1_gnt) begin
                outs($sformatf("t3_quiet%0d", c), 8'h00);
                chk($sformatf("t3_qaddr%0d", c), mem_addr, 0);
            end else if (prev == 2'b00 && n_g < 8) begin
                gseq[n_g] = p1_gnt;
                gcyc[n_g] = c;
                n_g++;
            end
            prev = {p0_gnt, p1_gnt};
            @(posedge clk);
            #1;
        end
        mem_out_valid = 0;
        chk("t3_ngrants", n_g, 4);
        for (int i = 0; i < 4 && i < n_g; i++) begin
            chk($sformatf("t3_port%0d", i), gseq[i], i % 2);
            chk($sformatf("t3_cyc%0d", i), gcyc[i], ecyc[i]);
        end

        // ---------------- T4: write with stalls, burstlen 4 -> 8 mid-burst
        wpat = 6'b101101;   // wrreq per WRITE cycle, bit k = cycle k
        mem_burstlen = 16'd4; p0_addr = 32'h7000; p0_wrreq = 1;
        #1 outs("t4_idle", 8'h00);
        nxt();
        for (int k = 0; k < 6; k++) begin
            p0_wrreq = wpat[k];
            p0_in = 32'hB000 + k;
            if (k == 1) mem_burstlen = 16'd8;
            #1 outs($sformatf("t4_w%0d", k), {1'b1, 3'b000, (k == 5), 2'b00, wpat[k]});
            nxt();
        end
        p0_wrreq = 0;
        #1 outs("t4_turn", 8'h00);
        nxt();

        // ---------------- T5: burstlen 0 read on port 1, stray mem_out_valid
        mem_burstlen = 16'd0; mem_out_valid = 1; p1_rdreq = 1; p1_addr = 32'h5000;
        #1 outs("t5_stray_idle", 8'h00);
        nxt();
        mem_out_valid = 0; p1_rdreq = 0;
        #1 outs("t5_rdreq", 8'b0100_0010);
        chk("t5_addr", mem_addr, 32'h5000);
        nxt();
        mem_out_valid = 1;
        #1 outs("t5_beat", 8'b0101_0100);
        nxt();
        #1 outs("t5_stray_turn", 8'h00);
        nxt();
        #1 outs("t5_stray_idle2", 8'h00);
        mem_out_valid = 0;
        nxt();

        // ---------------- T6: reset mid-read, then tie goes to port 0
        mem_burstlen = 16'd4; p0_addr = 32'h6000; p0_rdreq = 1;
        nxt();
        p0_rdreq = 0;
        #1 outs("t6_rdreq", 8'b1000_0010);
        nxt();
        mem_out_valid = 1;
        #1 outs("t6_beat1", 8'b1010_0000);
        nxt();
        #1 outs("t6_beat2", 8'b1010_0000);
        reset_n = 1'b0;
        #1 outs("t6_reset", 8'h00);
        chk("t6_reset_addr", mem_addr, 0);
        chk("t6_reset_out", p0_out, mem_out);
        mem_out_valid = 0;
        nxt();
        reset_n = 1'b1;
        p0_rdreq = 1; p1_rdreq = 1; p0_addr = 32'h8000; p1_addr = 32'h9000;
        #1 outs("t6_idle", 8'h00);
        nxt();
        #1 outs("t6_tie", 8'b1000_0010);
        chk("t6_tie_addr", mem_addr, 32'h8000);
        p0_rdreq = 0; p1_rdreq = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port burst arbiter sharing the single memory-controller port between the data cache (port 0) and the instruction cache (port 1). It grants one requester at a time for a complete burst, round-robins between ports, and inserts one idle turnaround cycle between bursts. It sits between the cache fill/flush engines and the memory controller.

## Interface
- DATABITS, 32, data width
- ADDRBITS, 32, address width
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- p0_addr / p1_addr  in  ADDRBITS  burst start address (reads) or per-beat address (writes)
- p0_in / p1_in  in  DATABITS  write data
- p0_rdreq / p1_rdreq  in  1  read-burst request, level
- p0_wrreq / p1_wrreq  in  1  write beat valid / write-burst request, level
- p0_gnt / p1_gnt  out  1  port owns the memory port
- p0_out / p1_out  out  DATABITS  mem_out broadcast
- p0_out_valid / p1_out_valid  out  1  read beat for this port
- p0_done / p1_done  out  1  one-cycle pulse on the last beat of this port's burst
- mem_addr  out  ADDRBITS  memory address
- mem_in  out  DATABITS  write data to memory
- mem_rdreq  out  1  read-burst start pulse
- mem_wrreq  out  1  write beat
- mem_out  in  DATABITS  read data
- mem_out_valid  in  1  read beat valid
- mem_burstlen  in  16  beats per burst

## Operation
- States: IDLE, READ, WRITE, TURN.
- IDLE: a port requests if rdreq|wrreq. If wrreq and rdreq are both high on one port, the request is a write. With one requester, it wins. With both, the port not granted last wins. After reset, the last-granted pointer is port 1, so port 0 wins the first tie.
- On grant, the following are latched: port id, direction, start address, and burstlen. mem_burstlen==0 is latched as 1. Later changes to mem_burstlen do not affect the burst in progress. Beat counter cleared; state goes to READ or WRITE.
- READ: mem_rdreq=1 and mem_addr=latched address for exactly the first READ cycle; afterwards mem_rdreq=0 and mem_addr holds. Each mem_out_valid cycle is one beat: the granted port's out_valid=1 and the counter increments. On the beat where count+1==burstlen: done pulses and the next state is TURN.
- WRITE: mem_addr, mem_in and mem_wrreq pass through combinationally from the granted port. mem_wrreq = granted wrreq. Each cycle with granted wrreq=1 is one beat. When wrreq is low, the burst stalls; this is not a cancel. The last beat pulses done and goes to TURN.
- The grant is held for the whole burst. Dropping rdreq mid-read is ignored and the read completes.
- TURN: one cycle, all memory outputs idle, gnt=0. Then IDLE.
- mem_out_valid outside READ is ignored (no out_valid, no count). The non-granted port never sees out_valid, done or gnt.
- Counter: 16 bits, compare against latched burstlen; no wrap possible.
- Reset mid-burst aborts immediately to IDLE with all outputs 0. Pointer returns to port 1.

## Timing
- Reset values: all gnt, out_valid, done, mem_rdreq, mem_wrreq = 0; mem_addr, mem_in = 0; p*_out = mem_out (combinational broadcast).
- State, grant, pointer and counters are registered. Memory-side outputs and out_valid/done are combinational from state plus inputs.
- The request is sampled at edge N in IDLE. gnt=1 and mem_rdreq (read) or write pass-through from cycle N+1.
- Minimum burst-to-burst spacing: last beat, then TURN, then IDLE, then the next grant. That is three cycles from the last beat edge to the next gnt.
- A read burst of L beats with zero memory latency occupies 1+L cycles in READ.
- out_valid has the same cycle as mem_out_valid.

## Test plan
- Single read, port 0, burstlen=4, beats at cycles 3,4,6,7 after mem_rdreq -> one mem_rdreq pulse with the latched address; p0_out_valid on the 4 beats; p0_done on the 4th; p1 signals all 0.
- Simultaneous p0_rdreq and p1_wrreq after reset -> port 0 granted first. Then TURN, IDLE, and port 1 granted; its 8 wrreq beats forwarded; p1_done on the 8th.
- Both ports requesting continuously, burstlen=2 -> grants alternate 0,1,0,1. No memory activity in TURN/IDLE cycles.
- Write burst with wrreq gaps, plus mem_burstlen changed 4->8 mid-burst -> burst ends after 4 beats counted only on wrreq=1 cycles.
- mem_burstlen=0 read -> treated as 1 beat; stray mem_out_valid in IDLE -> no out_valid.
- reset_n low mid-read (beat 2 of 4) -> all outputs 0 immediately. After release, a tie grants port 0.
